pump_scheduler: RTL and testbench

Central sequencer for the flood monitor's drain pump. Debounces btn0/btn7, tracks the switch-supplied water level, and runs the alarm → pump → done sequence. While pumping, it produces a simulated draining level. Drives display-source select, buzzer enable and pump status to the top level, replacing ad-hoc ctr/level muxing there.

---
 rtl/pump_scheduler_if.sv | 31 +++
 rtl/pump_scheduler.sv | 189 ++++++++++++++++++
 tb/tb_pump_scheduler.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/pump_scheduler_if.sv
// pump_scheduler_if: groups the pump scheduler's user-facing signals.
//   btn0, btn7        raw buttons (start/stop, speed toggle), active-high
//   sw_level_int/frac switch water level (integer metres, half-metre bit)
//   level_int/frac    displayed level
//   pump_on, fast_mode, disp_sel, beep_en, state   status outputs
// master: the side that drives buttons/switches (top level or bench).
// slave:  the scheduler itself.
`timescale 1ns/1ps
interface pump_scheduler_if;
  logic       btn0;
  logic       btn7;
  logic [3:0] sw_level_int;
  logic       sw_level_frac;
  logic [3:0] level_int;
  logic       level_frac;
  logic       pump_on;
  logic       fast_mode;
  logic       disp_sel;
  logic       beep_en;
  logic [1:0] state;

  modport master (
    output btn0, btn7, sw_level_int, sw_level_frac,
    input  level_int, level_frac, pump_on, fast_mode, disp_sel, beep_en, state
  );

  modport slave (
    input  btn0, btn7, sw_level_int, sw_level_frac,
    output level_int, level_frac, pump_on, fast_mode, disp_sel, beep_en, state
  );
endinterface

// File: rtl/pump_scheduler.sv
// pump_scheduler: drain-pump sequencer for the flood monitor.
// Debounces btn0/btn7, follows the switch water level, and runs
// IDLE -> ALARM -> PUMP -> DONE, simulating the draining level while pumping.
// Ports:
//   clk       system clock
//   rst       synchronous reset, active-high
//   sched_io  pump_scheduler_if.slave (buttons, switch level, status outputs)
// Optional build macro PUMP_AUTO_EN: ALARM lasting 4*TICK_DIV cycles starts
// the pump automatically; without it only btn0 starts the pump.
`timescale 1ns/1ps
module pump_scheduler #(
  parameter int unsigned TICK_DIV   = 50000000,
  parameter int unsigned DB_CYCLES  = 20,
  parameter int unsigned HIGH_LEVEL = 12,
  parameter int unsigned LOW_LEVEL  = 6
) (
  input logic              clk,
  input logic              rst,
  pump_scheduler_if.slave  sched_io
);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StAlarm = 2'b01,
    StPump  = 2'b10,
    StDone  = 2'b11
  } state_e;

  localparam int unsigned TickW    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DbW      = (DB_CYCLES > 1) ? $clog2(DB_CYCLES + 1) : 1;
  localparam logic [4:0]  HighHm   = 5'(2 * HIGH_LEVEL);
  localparam logic [4:0]  LowHm    = 5'(2 * LOW_LEVEL);
  localparam logic [TickW-1:0] SlowLast = TickW'(TICK_DIV - 1);
  localparam logic [TickW-1:0] FastLast = TickW'(TICK_DIV / 2 - 1);

  // Switch level in half-metres; integer 15 is out of range and clamps to 14.5.
  logic [4:0] sw_hm;
  always_comb begin
    sw_hm = {sched_io.sw_level_int, sched_io.sw_level_frac};
    if (sched_io.sw_level_int == 4'hF) sw_hm = 5'd29;
  end

  // ---------------------------------------------------------------------------
  // Button synchronizers and debouncers; bit 0 = btn0, bit 1 = btn7.
  // ---------------------------------------------------------------------------
  logic [1:0]     btn_raw;
  logic [1:0]     sync1_q, sync2_q, db_q, db_prev_q;
  logic [DbW-1:0] db_cnt_q [2];
  logic           p0, p7;

  always_comb btn_raw = {sched_io.btn7, sched_io.btn0};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      for (int i = 0; i < 2; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q   <= btn_raw;
      sync2_q   <= sync1_q;
      db_prev_q <= db_q;
      for (int i = 0; i < 2; i++) begin
        // Any sample equal to the accepted level restarts the run count.
        if (sync2_q[i] == db_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DbW'(DB_CYCLES - 1)) begin
          db_q[i]     <= sync2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + DbW'(1);
        end
      end
    end
  end

  assign p0 = db_q[0] & ~db_prev_q[0];
  assign p7 = db_q[1] & ~db_prev_q[1];

  // ---------------------------------------------------------------------------
  // Automatic pump start after a long alarm.
  // ---------------------------------------------------------------------------
  state_e state_q;
  logic   auto_go;

`ifdef PUMP_AUTO_EN
  localparam int unsigned AutoW = $clog2(4 * TICK_DIV);
  logic [AutoW-1:0] auto_cnt_q;

  always_ff @(posedge clk) begin
    if (rst || state_q != StAlarm) auto_cnt_q <= '0;
    else                           auto_cnt_q <= auto_cnt_q + AutoW'(1);
  end

  assign auto_go = (auto_cnt_q == AutoW'(4 * TICK_DIV - 1));
`else
  assign auto_go = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Sequencer FSM with registered outputs.
  // ---------------------------------------------------------------------------
  logic [4:0]       lvl_q, snap_q;
  logic [TickW-1:0] tick_q, tick_last;
  logic             fast_q, pump_on_q, disp_sel_q, beep_q;

  always_comb tick_last = fast_q ? FastLast : SlowLast;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      lvl_q      <= '0;
      snap_q     <= '0;
      tick_q     <= '0;
      fast_q     <= 1'b0;
      pump_on_q  <= 1'b0;
      disp_sel_q <= 1'b0;
      beep_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          lvl_q <= sw_hm;
          if (sw_hm >= HighHm) begin
            state_q <= StAlarm;
            beep_q  <= 1'b1;
          end
        end
        StAlarm: begin
          lvl_q <= sw_hm;
          if (sw_hm < HighHm) begin
            state_q <= StIdle;
            beep_q  <= 1'b0;
          end else if (p0 || auto_go) begin
            state_q    <= StPump;
            snap_q     <= sw_hm;
            tick_q     <= '0;
            pump_on_q  <= 1'b1;
            disp_sel_q <= 1'b1;
            beep_q     <= 1'b0;
          end
        end
        StPump: begin
          if (p0) begin
            // Abort wins over a simultaneous speed toggle.
            state_q    <= StIdle;
            fast_q     <= 1'b0;
            pump_on_q  <= 1'b0;
            disp_sel_q <= 1'b0;
          end else if (p7) begin
            fast_q <= ~fast_q;
            tick_q <= '0;
          end else if (lvl_q <= LowHm) begin
            // Only reachable when HIGH_LEVEL <= LOW_LEVEL.
            state_q    <= StDone;
            fast_q     <= 1'b0;
            pump_on_q  <= 1'b0;
            disp_sel_q <= 1'b0;
          end else if (tick_q == tick_last) begin
            // lvl_q > LowHm here, so the decrement cannot wrap below zero.
            tick_q <= '0;
            lvl_q  <= lvl_q - 5'd1;
            if (lvl_q == LowHm + 5'd1) begin
              state_q    <= StDone;
              fast_q     <= 1'b0;
              pump_on_q  <= 1'b0;
              disp_sel_q <= 1'b0;
            end
          end else begin
            tick_q <= tick_q + TickW'(1);
          end
        end
        StDone: begin
          if (sw_hm != snap_q) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign sched_io.level_int  = lvl_q[4:1];
  assign sched_io.level_frac = lvl_q[0];
  assign sched_io.pump_on    = pump_on_q;
  assign sched_io.fast_mode  = fast_q;
  assign sched_io.disp_sel   = disp_sel_q;
  assign sched_io.beep_en    = beep_q;
  assign sched_io.state      = state_q;

endmodule

// File: tb/tb_pump_scheduler.sv
// Bench for pump_scheduler with TICK_DIV=8, DB_CYCLES=2, HIGH=12, LOW=6.
// Level tracking in IDLE/ALARM is table-driven through an expectation queue;
// the pump, speed, abort, glitch, DONE and auto-start cases are hand sequences.
`timescale 1ns/1ps
module tb_pump_scheduler;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  pump_scheduler_if sif ();

  pump_scheduler #(
    .TICK_DIV   (8),
    .DB_CYCLES  (2),
    .HIGH_LEVEL (12),
    .LOW_LEVEL  (6)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sched_io (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] sw_int;
    logic       sw_frac;
    logic [3:0] lvl_int;
    logic       lvl_frac;
    logic [1:0] st;
    logic       beep;
  } vec_t;

  vec_t vecs [9];
  vec_t exp_q [$];

  function automatic void chk(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_sw(int li, int lf);
    sif.sw_level_int  = 4'(li);
    sif.sw_level_frac = 1'(lf);
  endtask

  // Hold the selected buttons for 4 cycles, then release; returns after 4 edges.
  task automatic press(logic b0, logic b7);
    sif.btn0 = b0;
    sif.btn7 = b7;
    step(4);
    sif.btn0 = 1'b0;
    sif.btn7 = 1'b0;
  endtask

  task automatic chk_lvl(string name, int li, int lf);
    chk({name, ".int"}, int'(sif.level_int), li);
    chk({name, ".frac"}, int'(sif.level_frac), lf);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    sif.btn0 = 1'b0;
    sif.btn7 = 1'b0;
    set_sw(13, 0);

    // Reset held 3 cycles.
    step(3);
    chk("rst.state", int'(sif.state), 0);
    chk_lvl("rst.level", 0, 0);
    chk("rst.pump_on", int'(sif.pump_on), 0);
    chk("rst.fast", int'(sif.fast_mode), 0);
    chk("rst.disp_sel", int'(sif.disp_sel), 0);
    chk("rst.beep", int'(sif.beep_en), 0);
    rst = 1'b0;
    step(1);
    chk_lvl("post_rst.level", 13, 0);
    chk("post_rst.state", int'(sif.state), 1);
    chk("post_rst.beep", int'(sif.beep_en), 1);

    // Table: one-cycle level tracking and IDLE/ALARM thresholds.
    vecs[0] = '{sw_int: 3,  sw_frac: 0, lvl_int: 3,  lvl_frac: 0, st: 0, beep: 0};
    vecs[1] = '{sw_int: 11, sw_frac: 1, lvl_int: 11, lvl_frac: 1, st: 0, beep: 0};
    vecs[2] = '{sw_int: 12, sw_frac: 0, lvl_int: 12, lvl_frac: 0, st: 1, beep: 1};
    vecs[3] = '{sw_int: 14, sw_frac: 1, lvl_int: 14, lvl_frac: 1, st: 1, beep: 1};
    vecs[4] = '{sw_int: 15, sw_frac: 0, lvl_int: 14, lvl_frac: 1, st: 1, beep: 1};
    vecs[5] = '{sw_int: 11, sw_frac: 1, lvl_int: 11, lvl_frac: 1, st: 0, beep: 0};
    vecs[6] = '{sw_int: 0,  sw_frac: 1, lvl_int: 0,  lvl_frac: 1, st: 0, beep: 0};
    vecs[7] = '{sw_int: 15, sw_frac: 1, lvl_int: 14, lvl_frac: 1, st: 1, beep: 1};
    vecs[8] = '{sw_int: 12, sw_frac: 1, lvl_int: 12, lvl_frac: 1, st: 1, beep: 1};
    for (int i = 0; i < 9; i++) begin
      vec_t e;
      set_sw(int'(vecs[i].sw_int), int'(vecs[i].sw_frac));
      exp_q.push_back(vecs[i]);
      step(1);
      e = exp_q.pop_front();
      chk($sformatf("vec%0d.level_int", i), int'(sif.level_int), int'(e.lvl_int));
      chk($sformatf("vec%0d.level_frac", i), int'(sif.level_frac), int'(e.lvl_frac));
      chk($sformatf("vec%0d.state", i), int'(sif.state), int'(e.st));
      chk($sformatf("vec%0d.beep", i), int'(sif.beep_en), int'(e.beep));
      chk($sformatf("vec%0d.pump_on", i), int'(sif.pump_on), 0);
    end

    // Full drain from 12.5 m at slow speed.
    set_sw(12, 1);
    step(2);
    press(1'b1, 1'b0);
    chk("start.state_e4", int'(sif.state), 1);
    step(1);
    chk("start.state_e5", int'(sif.state), 2);
    chk("start.pump_on", int'(sif.pump_on), 1);
    chk("start.disp_sel", int'(sif.disp_sel), 1);
    chk("start.beep", int'(sif.beep_en), 0);
    chk_lvl("start.level", 12, 1);
    set_sw(3, 0);  // ignored while pumping
    step(7);
    chk_lvl("slow.before_step", 12, 1);
    step(1);
    chk_lvl("slow.first_step", 12, 0);
    step(95);
    chk_lvl("slow.last_pump", 6, 1);
    chk("slow.still_pump", int'(sif.state), 2);
    set_sw(12, 1);  // back to the snapshot value before DONE
    step(1);
    chk("done.state", int'(sif.state), 3);
    chk_lvl("done.level", 6, 0);
    chk("done.pump_on", int'(sif.pump_on), 0);
    chk("done.disp_sel", int'(sif.disp_sel), 0);
    sif.btn0 = 1'b1;  // buttons ignored in DONE
    step(5);
    sif.btn0 = 1'b0;
    step(3);
    chk("done.hold_state", int'(sif.state), 3);
    chk_lvl("done.hold_level", 6, 0);
    set_sw(7, 0);
    step(1);
    chk("done_exit.state", int'(sif.state), 0);
    step(1);
    chk_lvl("done_exit.level", 7, 0);

    // Speed toggle: P is the PUMP entry edge.
    set_sw(13, 0);
    step(1);
    chk("fast.alarm", int'(sif.state), 1);
    press(1'b1, 1'b0);
    step(1);
    chk("fast.pump", int'(sif.state), 2);
    press(1'b0, 1'b1);
    step(1);                                       // P+5
    chk("fast.on", int'(sif.fast_mode), 1);
    chk_lvl("fast.on_level", 13, 0);
    step(3);                                       // P+8
    chk_lvl("fast.before_step", 13, 0);
    step(1);                                       // P+9
    chk_lvl("fast.step1", 12, 1);
    step(4);                                       // P+13
    chk_lvl("fast.step2", 12, 0);
    press(1'b0, 1'b1);                             // P+17
    chk_lvl("fast.step3", 11, 1);
    step(1);                                       // P+18
    chk("slow_again.fast", int'(sif.fast_mode), 0);
    chk_lvl("slow_again.level", 11, 1);
    step(7);                                       // P+25
    chk_lvl("slow_again.before_step", 11, 1);
    step(1);                                       // P+26
    chk_lvl("slow_again.step", 11, 0);

    // btn0 and btn7 together: abort wins, fast mode stays cleared.
    press(1'b1, 1'b1);
    step(1);                                       // P+31
    chk("both.state", int'(sif.state), 0);
    chk("both.fast", int'(sif.fast_mode), 0);
    chk("both.pump_on", int'(sif.pump_on), 0);
    step(1);
    chk_lvl("both.snap_level", 13, 0);
    chk("both.realarm", int'(sif.state), 1);

    // Glitchy btn0 must not start the pump.
    for (int i = 0; i < 5; i++) begin
      sif.btn0 = 1'b1;
      step(1);
      sif.btn0 = 1'b0;
      step(1);
      chk($sformatf("glitch%0d.state", i), int'(sif.state), 1);
    end
    step(6);
    chk("glitch.final_state", int'(sif.state), 1);
    chk("glitch.pump_on", int'(sif.pump_on), 0);

    // Long alarm with no buttons.
    set_sw(0, 0);
    step(1);
    chk("auto.idle", int'(sif.state), 0);
    set_sw(14, 0);
    step(1);
    chk("auto.alarm", int'(sif.state), 1);
    step(31);
    chk("auto.alarm_31", int'(sif.state), 1);
    step(1);
`ifdef PUMP_AUTO_EN
    chk("auto.pump_32", int'(sif.state), 2);
    chk("auto.pump_on", int'(sif.pump_on), 1);
    chk_lvl("auto.level", 14, 0);
`else
    chk("auto.alarm_32", int'(sif.state), 1);
    step(40);
    chk("auto.alarm_72", int'(sif.state), 1);
    chk("auto.pump_on", int'(sif.pump_on), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
